// File: rtl/opb_swreg_bank.sv
// opb_swreg_bank: OPB slave exposing C_NUM_REGS read/write control registers
// toward the user fabric and C_NUM_REGS read-only status words from it.
// Control registers take byte-enable writes. Every write produces a one-cycle
// strobe for the register it targets. Bits in C_PULSE_MASK clear themselves
// one cycle after being set.
module opb_swreg_bank #(
  parameter int unsigned             C_OPB_AWIDTH = 32,
  parameter int unsigned             C_OPB_DWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h01001000,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h010010FF,
  parameter                          C_FAMILY     = "virtex5",
  parameter int unsigned             C_NUM_REGS   = 4,
  parameter logic [31:0]             C_RESET_VAL  = 32'h00000000,
  parameter logic [31:0]             C_PULSE_MASK = 32'h00000000
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]    OPB_ABus,
  input  logic [0:3]                 OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]    OPB_DBus,
  input  logic                       OPB_RNW,
  input  logic                       OPB_select,
  input  logic                       OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]    Sl_DBus,
  output logic                       Sl_errAck,
  output logic                       Sl_retry,
  output logic                       Sl_toutSup,
  output logic                       Sl_xferAck,
  output logic [32*C_NUM_REGS-1:0]   user_data_out,
  output logic [C_NUM_REGS-1:0]      user_wr_stb,
  input  logic [32*C_NUM_REGS-1:0]   user_status_in
);

  localparam int unsigned N        = C_NUM_REGS;
  localparam int unsigned WW       = C_OPB_AWIDTH - 2;
  localparam logic [31:0] CTRL_RST = C_RESET_VAL & ~C_PULSE_MASK;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } state_t;

  state_t                  state_q;
  state_t                  state_d;

  logic [C_OPB_AWIDTH-1:0] addr;
  logic [C_OPB_AWIDTH-1:0] offset;
  logic [WW-1:0]           word;
  logic [31:0]             wdata;
  logic [3:0]              be;
  logic                    in_window;
  logic                    hit;

  logic [31:0]             ctrl_q [N];
  logic [31:0]             ctrl_d [N];
  logic [N-1:0]            stb_d;
  logic [N-1:0]            stb_q;
  logic [31:0]             rd_mux;
  logic [31:0]             rdata_q;

  logic                    unused_ok;

  // Assigning the OPB big-endian buses to descending vectors moves OPB bit 0
  // to bit 31. That makes BE[0] enable byte 3 (bits 31:24).
  assign addr   = OPB_ABus;
  assign wdata  = OPB_DBus;
  assign be     = OPB_BE;
  assign offset = addr - C_BASEADDR;
  assign word   = offset[C_OPB_AWIDTH-1:2];

  assign in_window = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  // A transfer is accepted only while idle, so a held select is never
  // acknowledged twice in a row.
  assign hit       = OPB_select && in_window && (state_q == ST_IDLE);

  // Bus handshake state register.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: acknowledge for exactly one cycle after a hit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hit) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read mux. Words past 2N inside the window fall through and read as zero.
  // Words are compared in full, so those addresses do not alias low registers.
  always_comb begin
    rd_mux = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (word == WW'(k))     rd_mux = ctrl_q[k];
      if (word == WW'(N + k)) rd_mux = user_status_in[32*k +: 32];
    end
  end

  // Control register update: clear pulse bits, then merge enabled bytes of a
  // write that targets this register.
  always_comb begin
    stb_d = '0;
    for (int unsigned k = 0; k < N; k++) begin
      ctrl_d[k] = ctrl_q[k] & ~C_PULSE_MASK;
      if (hit && !OPB_RNW && (word == WW'(k))) begin
        stb_d[k] = 1'b1;
        for (int unsigned b = 0; b < 4; b++) begin
          if (be[b]) ctrl_d[k][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  // Register storage, write strobes and the read-data register. Read data is
  // nonzero only in the acknowledge cycle.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int unsigned k = 0; k < N; k++) ctrl_q[k] <= CTRL_RST;
      stb_q   <= '0;
      rdata_q <= '0;
    end else begin
      for (int unsigned k = 0; k < N; k++) ctrl_q[k] <= ctrl_d[k];
      stb_q   <= stb_d;
      rdata_q <= (hit && OPB_RNW) ? rd_mux : '0;
    end
  end

  // Flatten the control registers onto the user-side output bus.
  always_comb begin
    user_data_out = '0;
    for (int unsigned k = 0; k < N; k++) user_data_out[32*k +: 32] = ctrl_q[k];
  end

  assign user_wr_stb = stb_q;
  assign Sl_DBus     = rdata_q;
  assign Sl_xferAck  = (state_q == ST_ACK);
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;

  assign unused_ok = &{1'b0, OPB_seqAddr, offset[1:0], C_FAMILY[0]};

endmodule
